// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lsu_mem_stage_if
// Purpose  : Bundles the three channels of the load/store unit.
//            - request  : execute -> LSU (req_*)
//            - data bus : LSU <-> data memory (mem_*)
//            - response : LSU -> register write-back (resp_*)
// Modports : slave  - the LSU's view (accepts requests, masters the bus)
//            master - the environment's view (execute, memory, write-back)
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_stage_if;

  // Request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  // Data-memory bus
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // Response channel
  logic        resp_valid;
  logic        resp_wb;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [1:0]  resp_err_code;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    output resp_valid, resp_wb, resp_rd, resp_data, resp_err, resp_err_code
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    input  resp_valid, resp_wb, resp_rd, resp_data, resp_err, resp_err_code
  );

endinterface
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lsu_mem_stage
// Purpose  : Load/store unit behind the execute ALU. Validates the access,
//            runs one word-wide bus transaction (req/ready handshake with an
//            optional timeout) and returns formatted load data or an error.
// Ports    : clk  - clock, all state on the rising edge
//            rst  - asynchronous active-high reset
//            bus  - lsu_mem_stage_if.slave (request, memory bus, response)
// Params   : TIMEOUT - bus cycles to wait for mem_ready (0 = wait forever)
//            CNT_W   - wait-counter width, must hold TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_stage_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  // The timeout fires on the edge where the counter would reach TIMEOUT,
  // so mem_req is high for exactly TIMEOUT bus cycles.
  localparam logic [CNT_W-1:0] c_tmo_last  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [1:0]       c_err_none  = 2'b00;
  localparam logic [1:0]       c_err_align = 2'b01;
  localparam logic [1:0]       c_err_ill   = 2'b10;
  localparam logic [1:0]       c_err_tmo   = 2'b11;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // Captured transaction
  logic        r_we;
  logic [31:0] r_addr;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;

  // Response registers
  logic        r_resp_valid, w_resp_valid;
  logic        r_resp_wb,    w_resp_wb;
  logic [4:0]  r_resp_rd,    w_resp_rd;
  logic [31:0] r_resp_data,  w_resp_data;
  logic        r_resp_err,   w_resp_err;
  logic [1:0]  r_resp_code,  w_resp_code;

  logic        w_capture;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_tmo;
  logic [31:0] w_st_wdata;
  logic [3:0]  w_st_wstrb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // --------------------------------------------------------------------------
  // Request validation
  // --------------------------------------------------------------------------
  always_comb begin
    w_illegal = 1'b0;
    if (bus.req_is_store) begin
      w_illegal = bus.req_funct3[2] || (bus.req_funct3[1:0] == 2'b11);
    end else begin
      w_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                  (bus.req_funct3 == 3'b111);
    end
    // funct3[1:0] encodes size for every legal code (00 byte, 01 half, 10 word)
    w_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  end

  // --------------------------------------------------------------------------
  // Store lane replication and byte enables (loads drive no strobes)
  // --------------------------------------------------------------------------
  always_comb begin
    w_st_wdata = '0;
    w_st_wstrb = '0;
    if (bus.req_is_store) begin
      case (bus.req_funct3[1:0])
        2'b00: begin
          w_st_wdata = {4{bus.req_wdata[7:0]}};
          w_st_wstrb = 4'b0001 << bus.req_addr[1:0];
        end
        2'b01: begin
          w_st_wdata = {2{bus.req_wdata[15:0]}};
          w_st_wstrb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          w_st_wdata = bus.req_wdata;
          w_st_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Load data extraction and extension
  // --------------------------------------------------------------------------
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = bus.mem_rdata;
    endcase
  end

  assign w_tmo = (TIMEOUT != 0) && (r_cnt == c_tmo_last);

  // --------------------------------------------------------------------------
  // Next-state and response logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_capture    = 1'b0;
    w_resp_valid = 1'b0;
    w_resp_wb    = 1'b0;
    w_resp_rd    = '0;
    w_resp_data  = '0;
    w_resp_err   = 1'b0;
    w_resp_code  = c_err_none;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_illegal || w_misalign) begin
            // Rejected without touching the bus; report on the next cycle
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
            w_resp_rd    = bus.req_rd;
            w_resp_code  = w_illegal ? c_err_ill : c_err_align;
          end else begin
            w_state_nxt = S_BUS;
            w_cnt_nxt   = '0;
            w_capture   = 1'b1;
          end
        end
      end
      S_BUS: begin
        // A completion in the expiry cycle still wins over the timeout
        if (bus.mem_ready) begin
          w_state_nxt  = S_IDLE;
          w_resp_valid = 1'b1;
          w_resp_rd    = r_rd;
          if (!r_we) begin
            w_resp_data = w_load_data;
            w_resp_wb   = (r_rd != 5'd0);
          end
        end else if (w_tmo) begin
          w_state_nxt  = S_IDLE;
          w_resp_valid = 1'b1;
          w_resp_rd    = r_rd;
          w_resp_err   = 1'b1;
          w_resp_code  = c_err_tmo;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Transaction capture and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_lane       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_wb    <= 1'b0;
      r_resp_rd    <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
      r_resp_code  <= c_err_none;
    end else begin
      if (w_capture) begin
        r_we     <= bus.req_is_store;
        r_addr   <= {bus.req_addr[31:2], 2'b00};
        r_lane   <= bus.req_addr[1:0];
        r_wdata  <= w_st_wdata;
        r_wstrb  <= w_st_wstrb;
        r_funct3 <= bus.req_funct3;
        r_rd     <= bus.req_rd;
      end
      r_resp_valid <= w_resp_valid;
      r_resp_wb    <= w_resp_wb;
      r_resp_rd    <= w_resp_rd;
      r_resp_data  <= w_resp_data;
      r_resp_err   <= w_resp_err;
      r_resp_code  <= w_resp_code;
    end
  end

  assign bus.req_ready     = (r_state == S_IDLE);
  assign bus.mem_req       = (r_state == S_BUS);
  assign bus.mem_we        = r_we;
  assign bus.mem_addr      = r_addr;
  assign bus.mem_wdata     = r_wdata;
  assign bus.mem_wstrb     = r_wstrb;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_wb       = r_resp_wb;
  assign bus.resp_rd       = r_resp_rd;
  assign bus.resp_data     = r_resp_data;
  assign bus.resp_err      = r_resp_err;
  assign bus.resp_err_code = r_resp_code;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lsu_mem_stage
// Purpose  : Directed self-checking bench for lsu_mem_stage. Expected
//            responses are queued as each request is driven and checked by a
//            monitor when resp_valid pulses; bus-side outputs are checked
//            inline by the stimulus tasks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;

  lsu_mem_stage_if ifc();

  lsu_mem_stage #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    logic [1:0]  code;
    logic        chk_rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic push_load(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.wb = (rd != 5'd0); e.rd = rd; e.data = data; e.err = 1'b0; e.code = 2'b00; e.chk_rd = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push_resp(input logic err, input logic [1:0] code);
    exp_t e;
    e.wb = 1'b0; e.rd = 5'd0; e.data = 32'h0; e.err = err; e.code = code; e.chk_rd = 1'b0;
    exp_q.push_back(e);
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ifc.resp_valid === 1'b1) begin
        chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_wb",   32'(ifc.resp_wb), 32'(e.wb));
          chk("resp_data", ifc.resp_data, e.data);
          chk("resp_err",  32'(ifc.resp_err), 32'(e.err));
          chk("resp_code", 32'(ifc.resp_err_code), 32'(e.code));
          if (e.chk_rd) chk("resp_rd", 32'(ifc.resp_rd), 32'(e.rd));
        end
      end else begin
        chk("resp_idle_data", ifc.resp_data, 32'h0);
        chk("resp_idle_flags", {23'h0, ifc.resp_wb, ifc.resp_err, ifc.resp_err_code, ifc.resp_rd}, 32'h0);
      end
    end
  end

  // Starts and ends on a falling edge; request is accepted on the rising edge between.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    chk("req_ready", 32'(ifc.req_ready), 32'd1);
    ifc.req_valid    = 1'b1;
    ifc.req_is_store = st;
    ifc.req_funct3   = f3;
    ifc.req_addr     = addr;
    ifc.req_wdata    = wd;
    ifc.req_rd       = rd;
    @(posedge clk);
    #1;
    ifc.req_valid    = 1'b0;
    ifc.req_is_store = 1'($urandom);
    ifc.req_funct3   = 3'($urandom);
    ifc.req_addr     = $urandom;
    ifc.req_wdata    = $urandom;
    ifc.req_rd       = 5'($urandom);
    @(negedge clk);
  endtask

  // Bus phase of a legal request: 'waits' stalled cycles, then mem_ready.
  task automatic bus_txn(input int waits, input logic [31:0] rdata, input logic we,
                         input logic [31:0] maddr, input logic [31:0] mwdata,
                         input logic [3:0] mwstrb);
    for (int i = 0; i <= waits; i++) begin
      chk("mem_req", 32'(ifc.mem_req), 32'd1);
      chk("mem_addr", ifc.mem_addr, maddr);
      if (i == 0) begin
        chk("mem_we", 32'(ifc.mem_we), 32'(we));
        chk("mem_wstrb", 32'(ifc.mem_wstrb), 32'(mwstrb));
        if (we) chk("mem_wdata", ifc.mem_wdata, mwdata);
      end
      ifc.mem_ready = (i == waits);
      ifc.mem_rdata = (i == waits) ? rdata : $urandom;
      @(negedge clk);
    end
    ifc.mem_ready = 1'b0;
    chk("mem_req_drop", 32'(ifc.mem_req), 32'd0);
    chk("resp_valid", 32'(ifc.resp_valid), 32'd1);
  endtask

  task automatic err_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [1:0] code);
    push_resp(1'b1, code);
    issue(st, f3, addr, $urandom, 5'd9);
    chk("err_no_mem_req", 32'(ifc.mem_req), 32'd0);
    chk("err_resp_valid", 32'(ifc.resp_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.req_valid = 1'b0; ifc.req_is_store = 1'b0; ifc.req_funct3 = 3'b0;
    ifc.req_addr = '0; ifc.req_wdata = '0; ifc.req_rd = '0;
    ifc.mem_ready = 1'b0; ifc.mem_rdata = '0;
    rst = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(ifc.req_ready), 32'd1);
    chk("rst_mem_ctl", {26'h0, ifc.mem_req, ifc.mem_we, ifc.mem_wstrb}, 32'h0);
    chk("rst_mem_addr", ifc.mem_addr, 32'h0);
    chk("rst_mem_wdata", ifc.mem_wdata, 32'h0);
    chk("rst_resp", {22'h0, ifc.resp_valid, ifc.resp_wb, ifc.resp_err, ifc.resp_err_code, ifc.resp_rd}, 32'h0);
    chk("rst_resp_data", ifc.resp_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Word load, minimum latency
    push_load(5'd5, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
    bus_txn(0, 32'hDEADBEEF, 1'b0, 32'h100, 32'h0, 4'b0000);

    // Byte/half loads
    push_load(5'd6, 32'hFFFFFF80);
    issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd6);
    bus_txn(0, 32'h80FF1234, 1'b0, 32'h100, 32'h0, 4'b0000);
    push_load(5'd7, 32'h00000080);
    issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd7);
    bus_txn(1, 32'h80FF1234, 1'b0, 32'h100, 32'h0, 4'b0000);
    push_load(5'd8, 32'h000080FF);
    issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd8);
    bus_txn(0, 32'h80FF1234, 1'b0, 32'h100, 32'h0, 4'b0000);
    push_load(5'd9, 32'h00001234);
    issue(1'b0, 3'b001, 32'h100, 32'h0, 5'd9);
    bus_txn(0, 32'h80FF1234, 1'b0, 32'h100, 32'h0, 4'b0000);
    push_load(5'd11, 32'hFFFF80FF);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 5'd11);
    bus_txn(0, 32'h80FF1234, 1'b0, 32'h100, 32'h0, 4'b0000);

    // Store lanes
    push_resp(1'b0, 2'b00);
    issue(1'b1, 3'b000, 32'h201, 32'h000000AB, 5'd1);
    bus_txn(0, 32'h0, 1'b1, 32'h200, 32'hABABABAB, 4'b0010);
    push_resp(1'b0, 2'b00);
    issue(1'b1, 3'b001, 32'h202, 32'h00001234, 5'd2);
    bus_txn(0, 32'h0, 1'b1, 32'h200, 32'h12341234, 4'b1100);
    push_resp(1'b0, 2'b00);
    issue(1'b1, 3'b001, 32'h200, 32'h0000BEEF, 5'd3);
    bus_txn(2, 32'h0, 1'b1, 32'h200, 32'hBEEFBEEF, 4'b0011);
    push_resp(1'b0, 2'b00);
    issue(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 5'd4);
    bus_txn(0, 32'h0, 1'b1, 32'h204, 32'hCAFEF00D, 4'b1111);

    // Errors (back-to-back: each request issued while the previous response is visible)
    err_txn(1'b0, 3'b010, 32'h102, 2'b01);
    err_txn(1'b0, 3'b011, 32'h100, 2'b10);
    err_txn(1'b0, 3'b111, 32'h103, 2'b10);
    err_txn(1'b1, 3'b101, 32'h101, 2'b10);
    err_txn(1'b1, 3'b001, 32'h203, 2'b01);
    err_txn(1'b0, 3'b001, 32'h101, 2'b01);

    // Wait states: five stalled cycles, then a single response pulse
    push_load(5'd10, 32'h11223344);
    issue(1'b0, 3'b010, 32'h108, 32'h0, 5'd10);
    bus_txn(5, 32'h11223344, 1'b0, 32'h108, 32'h0, 4'b0000);
    @(negedge clk);
    chk("single_pulse", 32'(ifc.resp_valid), 32'd0);

    // Timeout: mem_ready never arrives
    push_resp(1'b1, 2'b11);
    issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd12);
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("tmo_mem_req", 32'(ifc.mem_req), 32'd1);
      @(negedge clk);
    end
    chk("tmo_mem_req_drop", 32'(ifc.mem_req), 32'd0);
    chk("tmo_resp_valid", 32'(ifc.resp_valid), 32'd1);
    @(negedge clk);

    // mem_ready in the expiry cycle completes normally
    push_load(5'd13, 32'h5A5A0001);
    issue(1'b0, 3'b010, 32'h304, 32'h0, 5'd13);
    bus_txn(TIMEOUT - 1, 32'h5A5A0001, 1'b0, 32'h304, 32'h0, 4'b0000);

    // Reset in the third wait cycle
    issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd14);
    repeat (2) @(negedge clk);
    chk("pre_rst_mem_req", 32'(ifc.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 32'(ifc.mem_req), 32'd0);
    chk("async_rst_mem_addr", ifc.mem_addr, 32'h0);
    chk("async_rst_ready", 32'(ifc.req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Normal traffic after reset, then a load to x0
    push_load(5'd15, 32'h0BADF00D);
    issue(1'b0, 3'b010, 32'h404, 32'h0, 5'd15);
    bus_txn(1, 32'h0BADF00D, 1'b0, 32'h404, 32'h0, 4'b0000);
    push_load(5'd0, 32'h00000077);
    issue(1'b0, 3'b100, 32'h408, 32'h0, 5'd0);
    bus_txn(0, 32'h12345677, 1'b0, 32'h408, 32'h0, 4'b0000);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the execute stage's ALU.
- Takes the ALU-computed effective address, store data (rs2) and load/store funct3 from decode.
- Runs one word-wide data-memory transaction over a req/ready handshake.
- Returns formatted, sign/zero-extended load data with rd to register write-back, or an error; the core stalls fetch/PC while req_ready=0.

Parameters:
- TIMEOUT, 16: bus cycles mem_req may wait for mem_ready before a timeout error; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  execute presents a load or store
- req_ready  output  1  unit can accept (state IDLE)
- req_is_store  input  1  1=store (opcode 0100011), 0=load (opcode 0000011)
- req_funct3  input  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- req_addr  input  32  effective address (rs1 + imm)
- req_wdata  input  32  store data (rs2 value)
- req_rd  input  5  load destination register
- mem_req  output  1  bus request, held until mem_ready or timeout
- mem_we  output  1  1=write
- mem_addr  output  32  word-aligned address {req_addr[31:2],2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte enables
- mem_ready  input  1  bus completes in this cycle; mem_rdata valid when high
- mem_rdata  input  32  read word
- resp_valid  output  1  one-cycle completion pulse
- resp_wb  output  1  write resp_data to rf[resp_rd] (load, no error, rd!=0)
- resp_rd  output  5  destination register
- resp_data  output  32  formatted load data; 0 for stores and errors
- resp_err  output  1  access failed
- resp_err_code  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, resp_valid=0, resp_wb=0, resp_rd=0, resp_data=0, resp_err=0, resp_err_code=00, counter=0. req_ready=1 once state is IDLE. An in-flight bus transaction is abandoned with no response.
- States: IDLE, BUS. req_ready = (state==IDLE).
- Accept = req_valid && req_ready at a rising edge. All request fields are captured into internal registers; inputs may change afterwards.

Checks at accept:
- Illegal: loads with funct3 011/110/111; stores with funct3 other than 000/001/010.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- Illegal takes priority over misaligned.
- On either error: stay IDLE, no mem_req, and next cycle resp_valid=1, resp_err=1 with the matching code, resp_wb=0.

Legal access:
- Go to BUS; mem_req=1 from the next cycle.
- mem_addr, mem_we, mem_wdata and mem_wstrb stay stable until the transaction ends.

Store lanes:
- SB: wdata = {4{b}}, wstrb = 0001 << addr[1:0].
- SH: wdata = {2{h}}, wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1).
- SW: wdata unchanged, wstrb = 1111.
- Loads: wstrb = 0000.

BUS state:
- Counter increments each cycle mem_ready=0.
- mem_ready=1: mem_req drops next cycle, state returns to IDLE, and resp_valid pulses next cycle.
  - Load: resp_data is the byte/half selected by addr[1:0] and sign- or zero-extended per funct3; resp_wb = (rd!=0).
  - Store: resp_data=0, resp_wb=0.
- Timeout: when TIMEOUT!=0 and the counter reaches TIMEOUT, mem_req drops, state returns to IDLE, and resp_valid=1 with resp_err=1, code 11.
- If mem_ready=1 in the same cycle the counter reaches TIMEOUT, the ready completion wins and no error is reported.

Timing and pulses:
- Minimum latency: accept at edge 0, mem_req high in cycle 1; if mem_ready is high in cycle 1, resp_valid is high in cycle 2.
- resp_valid is exactly one cycle wide; all resp_* fields are 0 when resp_valid=0.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high.

Test Plan:
- Word load: LW addr=0x100, mem_ready in first bus cycle, rdata=0xDEADBEEF, rd=5 -> mem_addr=0x100, mem_wstrb=0000; 2 cycles after accept resp_valid=1, resp_wb=1, rd=5, data=0xDEADBEEF.
- Byte/half loads: LB addr=0x103, rdata=0x80FF1234 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x000080FF; LH addr=0x100 -> 0x00001234.
- Store lanes: SB addr=0x201, wdata=0x000000AB -> mem_wdata=0xABABABAB, wstrb=0010; SH addr=0x202, wdata=0x1234 -> mem_wdata=0x12341234, wstrb=1100; then resp_wb=0.
- Errors: LW addr=0x102 -> no mem_req, resp_err=1, code 01 next cycle; load funct3=011 -> code 10; both conditions together -> code 10.
- Wait and timeout: mem_ready delayed 5 cycles -> mem_req and mem_addr stable all 5 cycles, a single resp_valid. mem_ready never asserted with TIMEOUT=16 -> mem_req high 16 cycles then low, code 11. mem_ready at expiry -> normal completion, no error.
- Reset mid-BUS: assert rst in the 3rd wait cycle -> mem_req=0 immediately, no resp_valid; after release, the next request completes normally. A load with rd=0 completes with resp_wb=0.
